slow_tick_ctrl: RTL and testbench

SLOW_TICK_CTRL -- requirements
Module: slow_tick_ctrl

---
 rtl/slow_tick_pkg.sv | 11 +
 rtl/slow_tick_ctrl_divider.sv | 28 ++
 rtl/slow_tick_ctrl.sv | 83 ++++++++
 tb/tb_slow_tick_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/slow_tick_pkg.sv
// Shared types and default widths for the slow tick controller.
package slow_tick_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/slow_tick_ctrl_divider.sv
// Divide counter: produces a one-cycle tick every div_l enabled cycles.
module tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_l,
  output logic             tick
);
  logic [DIV_W-1:0] div_cnt_reg;
  logic             at_end;

  // div_l is never 0 while enabled, so div_l-1 cannot underflow in use.
  assign at_end = (div_cnt_reg == (div_l - DIV_W'(1)));
  assign tick   = enable && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (clear) begin
      div_cnt_reg <= '0;
    end else if (enable) begin
      div_cnt_reg <= at_end ? '0 : div_cnt_reg + DIV_W'(1);
    end
  end
endmodule

// File: rtl/slow_tick_ctrl.sv
// Slow-tick controller: issues cfg_count clock-enable ticks spaced cfg_div
// cycles apart, capturing a_in on each tick, with abort and done handshake.
module slow_tick_ctrl
  import slow_tick_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             abort,
  input  logic             a_in,
  output logic             tick,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);
  state_t           state_reg;
  logic [DIV_W-1:0] div_l_reg;
  logic [CNT_W-1:0] cnt_l_reg;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic             b_out_reg;
  logic             div_tick;
  logic             last_tick;

  tick_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .clk   (clk),
    .rst   (rst),
    .enable(state_reg == RUN),
    .clear (state_reg != RUN),
    .div_l (div_l_reg),
    .tick  (div_tick)
  );

  assign last_tick = (tick_cnt_reg == (cnt_l_reg - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_l_reg    <= '0;
      cnt_l_reg    <= '0;
      tick_cnt_reg <= '0;
      b_out_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            div_l_reg    <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            cnt_l_reg    <= cfg_count;
            tick_cnt_reg <= '0;
            state_reg    <= (cfg_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Abort wins over a coincident tick, including the terminal one.
          if (abort) begin
            state_reg <= IDLE;
          end else if (div_tick) begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
            b_out_reg    <= a_in;
            if (last_tick) begin
              state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tick     = div_tick;
  assign b_out    = b_out_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign tick_cnt = tick_cnt_reg;
endmodule

// File: tb/tb_slow_tick_ctrl.sv
// Self-checking bench for slow_tick_ctrl: directed table plus random runs
// checked cycle by cycle against an arithmetic model of tick timing.
module tb_slow_tick_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_count = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       a_in = 1'b0;
  logic       tick;
  logic       b_out;
  logic       busy;
  logic       done;
  logic [7:0] tick_cnt;

  int n_vec = 0;
  int n_mis = 0;
  int exp_b = 0;
  int obs_done, obs_ticks, obs_last;

  typedef struct {
    int d;
    int n;
    int ab;
    int a_val;
    int chg_at;
    int st_at;
    int exp_done;
    int exp_ticks;
    int exp_last;
    int exp_bout;
  } vec_t;

  vec_t tab[7];

  slow_tick_ctrl #(.DIV_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_div  (cfg_div),
    .cfg_count(cfg_count),
    .start    (start),
    .abort    (abort),
    .a_in     (a_in),
    .tick     (tick),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One run: launch from IDLE, then walk every cycle until the block is idle
  // again. Cycle k is the interval after the k-th rising edge past the start edge.
  task automatic run_txn(input int d, input int n, input int ab, input int a_val,
                         input int chg_at, input int st_at, input bit rnd);
    int dl, end_tick, last_k, m, ai;
    bit aborted, etick, busy_exp, eff;
    dl       = (d == 0) ? 1 : d;
    end_tick = n * dl;
    aborted  = (ab > 0) && (ab <= end_tick);
    last_k   = aborted ? ab + 2 : end_tick + 2;
    obs_done = 0; obs_ticks = 0; obs_last = 0;

    cfg_div   = 8'(d);
    cfg_count = 8'(n);
    start     = 1'b1;
    abort     = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      ai       = (a_val < 0) ? int'($urandom_range(0, 1)) : a_val;
      a_in     = ai[0];
      abort    = (k == ab);
      busy_exp = aborted ? (k <= ab) : (k <= end_tick + 1);
      if (rnd && busy_exp) begin
        start     = 1'($urandom_range(0, 1));
        cfg_div   = 8'($urandom);
        cfg_count = 8'($urandom);
      end else begin
        start = (k == st_at);
      end
      if (k == chg_at) cfg_div = 8'd7;
      @(negedge clk);
      etick = (k % dl == 0) && (k <= end_tick) && !(aborted && k > ab);
      eff   = etick && !(aborted && k >= ab);
      if (!(aborted && k == ab)) chk("tick", int'(tick), int'(etick));
      if (tick && !(aborted && k >= ab)) begin
        obs_ticks++;
        obs_last = k;
      end
      chk("busy", int'(busy), int'(busy_exp));
      chk("done", int'(done), int'(!aborted && k == end_tick + 1));
      if (done) obs_done = k;
      m = (aborted && k > ab) ? (ab - 1) / dl : (k - 1) / dl;
      if (m > n) m = n;
      chk("tick_cnt", int'(tick_cnt), m);
      chk("b_out", int'(b_out), exp_b);
      if (eff) exp_b = ai;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int d, n, ab, dl;
    //          d  n  ab a  chg st  done ticks last bout
    tab[0] = '{4, 3, 0, 1, 0, 0, 13, 3, 12, 1};  // basic run
    tab[1] = '{0, 2, 0, 0, 0, 0,  3, 2,  2, 0};  // div 0 acts as 1
    tab[2] = '{5, 0, 0, 1, 0, 0,  1, 0,  0, 0};  // zero count: straight to done
    tab[3] = '{3, 5, 7, 1, 0, 0,  0, 2,  6, 1};  // abort mid-run
    tab[4] = '{2, 4, 0, 0, 3, 3,  9, 4,  8, 0};  // cfg change + start while busy
    tab[5] = '{2, 2, 4, 1, 0, 0,  0, 1,  2, 1};  // abort on terminal tick
    tab[6] = '{1, 1, 0, 0, 0, 0,  2, 1,  1, 0};  // single tick, div 1

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_b_out", int'(b_out), 0);
    chk("rst_tick_cnt", int'(tick_cnt), 0);
    rst = 1'b0;
    exp_b = 0;

    for (int i = 0; i < 7; i++) begin
      run_txn(tab[i].d, tab[i].n, tab[i].ab, tab[i].a_val, tab[i].chg_at, tab[i].st_at, 1'b0);
      chk("done_cycle", obs_done, tab[i].exp_done);
      chk("n_ticks", obs_ticks, tab[i].exp_ticks);
      chk("last_tick", obs_last, tab[i].exp_last);
      chk("final_tick_cnt", int'(tick_cnt), tab[i].exp_ticks);
      chk("final_b_out", int'(b_out), tab[i].exp_bout);
      $display("vec %0d: div=%0d count=%0d abort_at=%0d done@%0d ticks=%0d", i,
               tab[i].d, tab[i].n, tab[i].ab, obs_done, obs_ticks);
    end

    // Asynchronous reset mid-run: div 3, count 4, a_in=1.
    cfg_div = 8'd3; cfg_count = 8'd4; a_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_tick_cnt", int'(tick_cnt), 1);
    chk("pre_rst_b_out", int'(b_out), 1);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_b_out", int'(b_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_tick_cnt", int'(tick_cnt), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    exp_b = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_done", int'(done), 0);
    end
    $display("mid-run reset sequence complete");

    for (int t = 0; t < 40; t++) begin
      d  = int'($urandom_range(0, 6));
      n  = int'($urandom_range(0, 6));
      dl = (d == 0) ? 1 : d;
      ab = 0;
      if (n > 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, n * dl));
      run_txn(d, n, ab, -1, 0, 0, 1'b1);
      $display("rnd %0d: div=%0d count=%0d abort_at=%0d done@%0d ticks=%0d", t,
               d, n, ab, obs_done, obs_ticks);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
